// File: rtl/serial_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_arbiter_if
// Description : Bundles the requester byte bus and the quick_rs232 transmit
//               handshake that serial_tx_arbiter sits between.
//               master : arbiter view (drives req_ack and the tx_* strobes)
//               slave  : environment view (requesters + transmitter)
// Signals     : req_valid/req_data/req_last  requester byte offers
//               req_ack                      1-cycle accept pulse per requester
//               tx_transaction/tx_data/tx_data_ready  to quick_rs232
//               tx_data_copied/tx_busy                from quick_rs232
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ack;

   logic                 tx_transaction;
   logic [7:0]           tx_data;
   logic                 tx_data_ready;
   logic                 tx_data_copied;
   logic                 tx_busy;

   modport master (
      input  req_valid, req_data, req_last, tx_data_copied, tx_busy,
      output req_ack, tx_transaction, tx_data, tx_data_ready
   );

   modport slave (
      output req_valid, req_data, req_last, tx_data_copied, tx_busy,
      input  req_ack, tx_transaction, tx_data, tx_data_ready
   );
endinterface
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_arbiter
// Description : Round-robin arbiter sharing one quick_rs232 transmitter among
//               NUM_REQ byte producers. Sequences open / load / send / hold /
//               drain for every byte and locks the grant to one requester for
//               the whole of a multi-byte packet.
// Ports       : clk          system clock
//               rst          asynchronous, active-low reset
//               bus          requester bus + transmitter handshake (master)
//               grant_id     index of current owner, valid while busy=1
//               busy         a packet is in progress
//               timeout_err  1-cycle pulse when a copy or next byte times out
// Parameters  : NUM_REQ (1..8), SETUP_DELAY, HOLD_CYCLES, TIMEOUT_CYCLES
//               (delay parameters are treated as at least 1)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SETUP_DELAY    = 10,
   parameter int HOLD_CYCLES    = 10,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  wire logic           clk,
   input  wire logic           rst,
   serial_tx_arbiter_if.master bus,
   output logic [2:0]          grant_id,
   output logic                busy,
   output logic                timeout_err
);

   // Terminal counts: the counter runs 0..N-1, so the action fires on the
   // N-th clock edge after entering the state.
   localparam int          c_SETUP_N   = (SETUP_DELAY    > 0) ? SETUP_DELAY    : 1;
   localparam int          c_HOLD_N    = (HOLD_CYCLES    > 0) ? HOLD_CYCLES    : 1;
   localparam int          c_TMO_N     = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
   localparam logic [15:0] c_SETUP_END = 16'(c_SETUP_N - 1);
   localparam logic [15:0] c_HOLD_END  = 16'(c_HOLD_N - 1);
   localparam logic [15:0] c_TMO_END   = 16'(c_TMO_N - 1);
   localparam logic [2:0]  c_LAST_IDX  = 3'(NUM_REQ - 1);
   localparam logic [3:0]  c_NUM_REQ   = 4'(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_OPEN      = 3'd1,
      S_SEND      = 3'd2,
      S_HOLD      = 3'd3,
      S_WAIT_NEXT = 3'd4,
      S_DRAIN     = 3'd5
   } state_t;

   state_t               r_state;
   logic [2:0]           r_ptr;
   logic [2:0]           r_grant_id;
   logic                 r_last;
   logic [15:0]          r_cnt;
   logic                 r_busy;
   logic                 r_timeout_err;
   logic                 r_tx_transaction;
   logic [7:0]           r_tx_data;
   logic                 r_tx_data_ready;
   logic [NUM_REQ-1:0]   r_req_ack;

   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic                 w_win_found;
   logic [2:0]           w_win_off;
   logic [3:0]           w_win_sum;
   logic [2:0]           w_win_idx;
   logic [2:0]           w_sel;
   logic                 w_sel_valid;
   logic [7:0]           w_sel_data;
   logic                 w_sel_last;
   logic [NUM_REQ-1:0]   w_sel_onehot;
   logic [15:0]          w_cnt_inc;
   logic [2:0]           w_ptr_next;

   // ------------------------------------------------------------------------
   // Round-robin winner: rotate the request vector so that bit 0 is the
   // pointer position, take the lowest set bit, then rotate the offset back.
   // ------------------------------------------------------------------------
   always_comb begin
      w_req_dbl   = {bus.req_valid, bus.req_valid};
      w_req_rot   = NUM_REQ'(w_req_dbl >> r_ptr);
      w_win_found = 1'b0;
      w_win_off   = 3'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_win_found = 1'b1;
            w_win_off   = 3'(k);
         end
      end
      w_win_sum = {1'b0, r_ptr} + {1'b0, w_win_off};
      w_win_idx = (w_win_sum >= c_NUM_REQ) ? 3'(w_win_sum - c_NUM_REQ)
                                           : w_win_sum[2:0];
   end

   // ------------------------------------------------------------------------
   // Requester slice selection: the fresh winner while idle, otherwise the
   // locked owner. Only the owner's slice is ever looked at mid-packet.
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel        = (r_state == S_IDLE) ? w_win_idx : r_grant_id;
      w_sel_valid  = 1'b0;
      w_sel_data   = 8'h00;
      w_sel_last   = 1'b0;
      w_sel_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == 3'(i)) begin
            w_sel_valid     = bus.req_valid[i];
            w_sel_data      = bus.req_data[8*i +: 8];
            w_sel_last      = bus.req_last[i];
            w_sel_onehot[i] = 1'b1;
         end
      end
   end

   // Saturating so a stuck state can never wrap back into a short count.
   assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   assign w_ptr_next = (r_grant_id == c_LAST_IDX) ? 3'd0 : r_grant_id + 3'd1;

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= S_IDLE;
         r_ptr            <= 3'd0;
         r_grant_id       <= 3'd0;
         r_last           <= 1'b0;
         r_cnt            <= 16'd0;
         r_busy           <= 1'b0;
         r_timeout_err    <= 1'b0;
         r_tx_transaction <= 1'b0;
         r_tx_data        <= 8'h00;
         r_tx_data_ready  <= 1'b0;
         r_req_ack        <= '0;
      end else begin
         r_req_ack     <= '0;
         r_timeout_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_win_found) begin
                  r_tx_data        <= w_sel_data;
                  r_last           <= w_sel_last;
                  r_req_ack        <= w_sel_onehot;
                  r_grant_id       <= w_win_idx;
                  r_tx_transaction <= 1'b1;
                  r_busy           <= 1'b1;
                  r_cnt            <= 16'd0;
                  r_state          <= S_OPEN;
               end
            end

            S_OPEN: begin
               if (r_cnt >= c_SETUP_END) begin
                  r_tx_data_ready <= 1'b1;
                  r_cnt           <= 16'd0;
                  r_state         <= S_SEND;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            S_SEND: begin
               // A copy on the same edge as the timeout still counts.
               if (bus.tx_data_copied) begin
                  r_cnt   <= 16'd0;
                  r_state <= S_HOLD;
               end else if (r_cnt >= c_TMO_END) begin
                  r_timeout_err   <= 1'b1;
                  r_tx_data_ready <= 1'b0;
                  r_cnt           <= 16'd0;
                  r_state         <= S_DRAIN;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            S_HOLD: begin
               if (r_cnt >= c_HOLD_END) begin
                  r_tx_data_ready <= 1'b0;
                  r_cnt           <= 16'd0;
                  r_state         <= r_last ? S_DRAIN : S_WAIT_NEXT;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            S_WAIT_NEXT: begin
               // The transmitter is already open, so the next byte of the
               // packet goes straight to SEND without a setup delay.
               if (w_sel_valid) begin
                  r_tx_data       <= w_sel_data;
                  r_last          <= w_sel_last;
                  r_req_ack       <= w_sel_onehot;
                  r_tx_data_ready <= 1'b1;
                  r_cnt           <= 16'd0;
                  r_state         <= S_SEND;
               end else if (r_cnt >= c_TMO_END) begin
                  r_timeout_err <= 1'b1;
                  r_cnt         <= 16'd0;
                  r_state       <= S_DRAIN;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            S_DRAIN: begin
               if (!bus.tx_busy) begin
                  r_tx_transaction <= 1'b0;
                  r_tx_data        <= 8'h00;
                  r_ptr            <= w_ptr_next;
                  r_busy           <= 1'b0;
                  r_cnt            <= 16'd0;
                  r_state          <= S_IDLE;
               end
            end

            default: begin
               r_tx_transaction <= 1'b0;
               r_tx_data_ready  <= 1'b0;
               r_busy           <= 1'b0;
               r_cnt            <= 16'd0;
               r_state          <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ack        = r_req_ack;
   assign bus.tx_transaction = r_tx_transaction;
   assign bus.tx_data        = r_tx_data;
   assign bus.tx_data_ready  = r_tx_data_ready;
   assign grant_id           = r_grant_id;
   assign busy               = r_busy;
   assign timeout_err        = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_arbiter
// Description : Directed bench for serial_tx_arbiter with a simple
//               quick_rs232 stand-in (copies 5 cycles after tx_data_ready,
//               stays busy 20 cycles) and a log of every copied byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

   localparam int c_LIMIT = 1000;

   logic       clk;
   logic       rst;
   logic [2:0] grant_id;
   logic       busy;
   logic       timeout_err;
   logic       copy_en;

   int         checks;
   int         failures;
   logic [7:0] log_q[$];

   serial_tx_arbiter_if #(.NUM_REQ(4)) bus ();

   serial_tx_arbiter #(
      .NUM_REQ        (4),
      .SETUP_DELAY    (10),
      .HOLD_CYCLES    (10),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.master),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter stand-in.
   initial begin : transmitter
      int wcnt;
      int bcnt;
      bit done;
      wcnt = 0; bcnt = 0; done = 1'b0;
      bus.tx_data_copied = 1'b0;
      bus.tx_busy        = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_data_copied = 1'b0;
         if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) bus.tx_busy = 1'b0;
         end
         if (!bus.tx_data_ready) begin
            wcnt = 0;
            done = 1'b0;
         end else if (copy_en && !done) begin
            wcnt++;
            if (wcnt == 5) begin
               bus.tx_data_copied = 1'b1;
               bus.tx_busy        = 1'b1;
               bcnt               = 20;
               done               = 1'b1;
               log_q.push_back(bus.tx_data);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output logic [3:0] ack, output bit saw_idle);
      int n;
      n = 0;
      saw_idle = 1'b0;
      do begin
         step();
         n++;
         if (!busy) saw_idle = 1'b1;
      end while (bus.req_ack == 4'b0000 && n < c_LIMIT);
      ack = bus.req_ack;
   endtask

   task automatic wait_ready(input logic lvl, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.tx_data_ready !== lvl && n < c_LIMIT);
   endtask

   task automatic wait_trans_low(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.tx_transaction !== 1'b0 && n < c_LIMIT);
   endtask

   task automatic wait_timeout(output int n, output logic [3:0] acks);
      n = 0;
      acks = 4'b0000;
      do begin
         step();
         n++;
         acks = acks | bus.req_ack;
      end while (timeout_err !== 1'b1 && n < c_LIMIT);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < c_LIMIT) begin
         step();
         n++;
      end
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   task automatic set_req(input int idx, input logic [7:0] data, input logic last);
      bus.req_data[8*idx +: 8] = data;
      bus.req_last[idx]        = last;
      bus.req_valid[idx]       = 1'b1;
   endtask

   initial begin : main
      logic [3:0] ack;
      logic [3:0] acks;
      bit         idle_seen;
      int         n;
      logic [7:0] exp_log[12];

      exp_log = '{8'h41, 8'hA1, 8'hA3, 8'hC0, 8'hC1, 8'h10,
                  8'h11, 8'h12, 8'hB0, 8'h55, 8'hD3, 8'h78};
      checks = 0;
      failures = 0;
      copy_en = 1'b1;
      rst = 1'b0;
      bus.req_valid = 4'b0000;
      bus.req_data  = 32'h0;
      bus.req_last  = 4'b0000;

      // ---- reset state ----
      repeat (3) step();
      check("rst_outputs",
            {16'd0, bus.tx_transaction, bus.tx_data_ready, busy, timeout_err,
             bus.req_ack, bus.tx_data},
            32'd0);
      check("rst_grant", {29'd0, grant_id}, 32'd0);
      rst = 1'b1;
      step();

      // ---- single byte ----
      set_req(0, 8'h41, 1'b1);
      wait_ack(ack, idle_seen);
      check("single_ack", {28'd0, ack}, 32'h1);
      check("single_open", {29'd0, bus.tx_transaction, busy, bus.tx_data_ready}, 32'b110);
      bus.req_valid[0] = 1'b0;
      wait_ready(1'b1, n);
      check("single_setup_cycles", n, 10);
      check("single_data", {24'd0, bus.tx_data}, 32'h41);
      wait_ready(1'b0, n);
      check("single_ready_high", n, 15);
      wait_trans_low(n);
      check("single_drain_cycles", n, 10);
      check("single_done", {23'd0, busy, bus.tx_data}, 32'd0);

      // ---- contention ----
      set_req(1, 8'hA1, 1'b1);
      set_req(3, 8'hA3, 1'b1);
      wait_ack(ack, idle_seen);
      check("cont_first_ack", {28'd0, ack}, 32'b0010);
      check("cont_first_grant", {29'd0, grant_id}, 32'd1);
      bus.req_valid[1] = 1'b0;
      wait_ack(ack, idle_seen);
      check("cont_second_ack", {28'd0, ack}, 32'b1000);
      check("cont_second_grant", {29'd0, grant_id}, 32'd3);
      check("cont_gap_idle", {31'd0, idle_seen}, 32'd1);
      bus.req_valid[3] = 1'b0;
      wait_idle();
      set_req(0, 8'hC0, 1'b1);
      set_req(1, 8'hC1, 1'b1);
      wait_ack(ack, idle_seen);
      check("wrap_first_ack", {28'd0, ack}, 32'b0001);
      bus.req_valid[0] = 1'b0;
      wait_ack(ack, idle_seen);
      check("wrap_second_ack", {28'd0, ack}, 32'b0010);
      bus.req_valid[1] = 1'b0;
      wait_idle();

      // ---- packet lock ----
      set_req(0, 8'hB0, 1'b1);
      set_req(2, 8'h10, 1'b0);
      wait_ack(ack, idle_seen);
      check("pkt_b0_ack", {28'd0, ack}, 32'b0100);
      check("pkt_b0_ready", {31'd0, bus.tx_data_ready}, 32'd0);
      bus.req_data[23:16] = 8'h11;
      wait_ack(ack, idle_seen);
      check("pkt_b1_ack", {28'd0, ack}, 32'b0100);
      check("pkt_b1_state", {20'd0, bus.tx_transaction, bus.tx_data_ready, busy, 1'b0, bus.tx_data},
            {20'd0, 4'b1110, 8'h11});
      bus.req_data[23:16] = 8'h12;
      bus.req_last[2]     = 1'b1;
      wait_ack(ack, idle_seen);
      check("pkt_b2_ack", {28'd0, ack}, 32'b0100);
      check("pkt_b2_state", {20'd0, bus.tx_transaction, bus.tx_data_ready, busy, 1'b0, bus.tx_data},
            {20'd0, 4'b1110, 8'h12});
      check("pkt_no_gap", {31'd0, idle_seen}, 32'd0);
      bus.req_valid[2] = 1'b0;
      wait_ack(ack, idle_seen);
      check("pkt_waiter_ack", {28'd0, ack}, 32'b0001);
      check("pkt_waiter_after_drain", {31'd0, idle_seen}, 32'd1);
      bus.req_valid[0] = 1'b0;
      wait_idle();

      // ---- copy timeout ----
      copy_en = 1'b0;
      set_req(0, 8'hE0, 1'b1);
      wait_ack(ack, idle_seen);
      check("tmo_ack", {28'd0, ack}, 32'b0001);
      bus.req_valid[0] = 1'b0;
      wait_ready(1'b1, n);
      check("tmo_setup_cycles", n, 10);
      wait_timeout(n, acks);
      check("tmo_cycles", n, 100);
      check("tmo_ready_dropped", {30'd0, bus.tx_data_ready, bus.tx_transaction}, 32'b01);
      step();
      check("tmo_pulse_end", {31'd0, timeout_err}, 32'd0);
      check("tmo_idle", {30'd0, bus.tx_transaction, busy}, 32'd0);
      copy_en = 1'b1;

      // ---- stalled packet ----
      set_req(1, 8'h55, 1'b0);
      wait_ack(ack, idle_seen);
      check("stall_ack", {28'd0, ack}, 32'b0010);
      bus.req_valid[1] = 1'b0;
      set_req(3, 8'hD3, 1'b1);
      wait_ready(1'b1, n);
      wait_ready(1'b0, n);
      check("stall_ready_high", n, 15);
      wait_timeout(n, acks);
      check("stall_cycles", n, 100);
      check("stall_no_foreign_ack", {28'd0, acks}, 32'd0);
      wait_ack(ack, idle_seen);
      check("stall_next_ack", {28'd0, ack}, 32'b1000);
      check("stall_next_after_idle", {31'd0, idle_seen}, 32'd1);
      bus.req_valid[3] = 1'b0;
      wait_idle();

      // ---- async reset mid-SEND ----
      copy_en = 1'b0;
      set_req(2, 8'h77, 1'b1);
      wait_ack(ack, idle_seen);
      bus.req_valid[2] = 1'b0;
      wait_ready(1'b1, n);
      repeat (3) step();
      #2;
      rst = 1'b0;
      #1;
      check("arst_immediate",
            {20'd0, bus.tx_transaction, bus.tx_data_ready, busy, 1'b0, bus.tx_data}, 32'd0);
      step();
      rst = 1'b1;
      copy_en = 1'b1;
      set_req(2, 8'h78, 1'b1);
      wait_ack(ack, idle_seen);
      check("arst_new_ack", {28'd0, ack}, 32'b0100);
      check("arst_new_grant", {29'd0, grant_id}, 32'd2);
      bus.req_valid[2] = 1'b0;
      wait_ready(1'b1, n);
      check("arst_setup_cycles", n, 10);
      wait_idle();
      repeat (3) step();

      // ---- copied byte log ----
      check("log_size", log_q.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < log_q.size())
            check($sformatf("log_%0d", i), {24'd0, log_q[i]}, {24'd0, exp_log[i]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
